// File: rtl/gate_vector_checker.sv
// Synthesizable stimulus-and-check stage for a 2-input AND gate: sweeps {a,b}, samples y, tallies mismatches.
// Optional macro GVC_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_err_vec
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

`ifdef GVC_STOP_ON_ERR_EN
  localparam logic STOP_ON_ERR = 1'b1;
`else
  localparam logic STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;
  logic [ERR_W-1:0]   r_err, w_err_nxt;
  logic [VEC_W-1:0]   r_first, w_first_nxt;
  logic               r_pass, w_pass_nxt;
  logic               r_busy, r_done;
  logic               w_mis;

  assign w_mis = y ^ (r_vec[1] & r_vec[0]);

  // State and all observable outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vec   <= w_vec_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    w_pass_nxt  = r_pass;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_APPLY;
          w_cnt_nxt   = CNT_LOAD;
          w_vec_nxt   = '0;
          w_err_nxt   = '0;
          w_first_nxt = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_APPLY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (w_mis) begin
          w_err_nxt = r_err + ERR_W'(1);
          if (r_err == '0) begin
            w_first_nxt = r_vec;
          end
        end
        // Last vector, or early exit on the first mismatch when enabled.
        if ((r_vec == VEC_LAST) || (STOP_ON_ERR && w_mis)) begin
          w_state_nxt = S_DONE;
          w_vec_nxt   = '0;
          w_pass_nxt  = (w_err_nxt == '0);
        end else begin
          w_state_nxt = S_APPLY;
          w_vec_nxt   = r_vec + VEC_W'(1);
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign a             = r_vec[1];
  assign b             = r_vec[0];
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_vec = r_first;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: good AND, stuck-at-0/1 and OR gates, restart and reset mid-sweep.
module tb_gate_vector_checker;

  localparam int unsigned S = 2;
  localparam int PER = S + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] first_err_vec;

  int mode;  // 0 AND, 1 stuck-0, 2 stuck-1, 3 OR
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       y = 1'b0;
      2:       y = 1'b1;
      3:       y = a | b;
      default: y = a & b;
    endcase
  end

  gate_vector_checker #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_vec(first_err_vec)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " a"}, int'(a), 0);
    chk({tag, " b"}, int'(b), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " err"}, int'(err_count), 0);
    chk({tag, " first"}, int'(first_err_vec), 0);
  endtask

  // Called #1 after a rising edge; that cycle becomes cycle 0.
  task automatic run_sweep(input string nm, input int exp_err, input int exp_first,
                           input int exp_done_cyc, input int again_cyc, input int rst_cyc);
    int cyc;
    bit seen;
    cyc   = 0;
    seen  = 1'b0;
    start = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == again_cyc);
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk_reset_vals({nm, " async rst"});
        rst = 1'b0;
        return;
      end
      if (done) begin
        seen = 1'b1;
        chk({nm, " done cycle"}, cyc, exp_done_cyc);
        chk({nm, " busy@done"}, int'(busy), 1);
        chk({nm, " ab@done"}, int'({a, b}), 0);
        chk({nm, " pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
        chk({nm, " err"}, int'(err_count), exp_err);
        chk({nm, " first"}, int'(first_err_vec), exp_first);
      end else begin
        chk({nm, " busy"}, int'(busy), 1);
        chk({nm, " ab"}, int'({a, b}), (cyc - 1) / PER);
        if (cyc == 1) chk({nm, " pass cleared"}, int'(pass), 0);
      end
    end
    if (!seen) chk({nm, " done timeout"}, 0, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk({nm, " idle busy"}, int'(busy), 0);
    chk({nm, " idle done"}, int'(done), 0);
    chk({nm, " idle ab"}, int'({a, b}), 0);
    chk({nm, " held pass"}, int'(pass), (exp_err == 0) ? 1 : 0);
    chk({nm, " held err"}, int'(err_count), exp_err);
    chk({nm, " held first"}, int'(first_err_vec), exp_first);
  endtask

  initial begin
    mode  = 0;
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    mode = 0;
    run_sweep("and", 0, 0, 13, -1, -1);

`ifdef GVC_STOP_ON_ERR_EN
    mode = 1;
    run_sweep("stuck0", 1, 3, 13, -1, -1);
    mode = 2;
    run_sweep("stuck1", 1, 0, 4, -1, -1);
    mode = 3;
    run_sweep("or", 1, 1, 7, -1, -1);
`else
    mode = 1;
    run_sweep("stuck0", 1, 3, 13, -1, -1);
    mode = 2;
    run_sweep("stuck1", 3, 0, 13, -1, -1);
    mode = 3;
    run_sweep("or", 2, 1, 13, -1, -1);
`endif

    mode = 0;
    run_sweep("restart ignored", 0, 0, 13, 5, -1);

    mode = 3;
    run_sweep("rst mid", 0, 0, 13, -1, 7);
    @(posedge clk); #1;
    chk_reset_vals("after rst");
    mode = 0;
    run_sweep("post rst", 0, 0, 13, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Sequential stimulus-and-check stage wrapped around a 2-input AND gate. On `start` it drives the gate's `a`/`b` inputs through all four input combinations, waits a programmable settle time for each, samples the gate output `y`, and compares it with the expected `a & b`. It reports a mismatch count, the first failing vector, and pass/done status. It replaces hand-written `initial` stimulus with a synthesizable self-check usable on hardware.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles each vector is held before `y` is sampled. Legal range 1..15.

Ports:
- `clk` input, 1 bit: single clock; everything is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: begin a sweep. Sampled only in IDLE.
- `y` input, 1 bit: output of the gate under check.
- `a` output, 1 bit: gate input A, registered.
- `b` output, 1 bit: gate input B, registered.
- `busy` output, 1 bit: high while a sweep is in progress.
- `done` output, 1 bit: one-cycle pulse when a sweep ends.
- `pass` output, 1 bit: result of the last sweep; 1 means no mismatches. Held until the next `start`.
- `err_count` output, 3 bits: number of mismatching vectors, 0..4.
- `first_err_vec` output, 2 bits: `{a,b}` of the first mismatch. Valid when `err_count != 0`.

## Operation
- The vector register `vec[1:0]` drives `{a,b}` and steps 00 → 01 → 10 → 11.
- States:
  - IDLE: `a=b=0`, `busy=0`. If `start`=1, go to APPLY with `vec=0`, settle counter = `SETTLE_CYC-1`, `err_count=0`, `first_err_vec=0`, `pass=0`.
  - APPLY: `busy=1`. Count the settle counter down to 0, then go to CHECK.
  - CHECK: sample `y` and compare with `vec[1] & vec[0]`.
    - On mismatch: `err_count += 1`. If `err_count` was 0 before this increment, capture `first_err_vec = vec`.
    - If `vec==3`, go to DONE. Otherwise `vec += 1`, reload the counter, and go to APPLY.
  - DONE: `done=1` for exactly one cycle, `pass = (err_count==0)`, `vec=0` (so `a=b=0`), then go to IDLE.
- `start` while `busy=1` is ignored. `start` held high in IDLE starts back-to-back sweeps.
- `err_count` saturates naturally at 4 because there are only 4 vectors. It never wraps.
- `err_count` and `first_err_vec` hold their values in IDLE until the next `start`.

## Timing
- Reset values: `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `first_err_vec=0`, state IDLE.
- Asserting `rst` mid-sweep returns all outputs to these values immediately, without waiting for a clock edge. No partial result is reported.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled in IDLE. The first vector appears on `a`/`b` in cycle 1.
- Each vector occupies `SETTLE_CYC+1` cycles: `SETTLE_CYC` in APPLY plus 1 in CHECK.
- The check for vector k happens in cycle (k+1)·(`SETTLE_CYC`+1).
- `done` is high in cycle 4·(`SETTLE_CYC`+1)+1. With the default of 2, that is cycle 13.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `y` is a combinational function of the registered `a`/`b`, so it must be stable by the CHECK cycle. `SETTLE_CYC`≥1 guarantees this.

## Configuration
- `GVC_STOP_ON_ERR_EN` defined: the first mismatch in CHECK goes straight to DONE.
  - Result: `err_count=1`, `first_err_vec` = the failing vector, `pass=0`.
  - `done` asserts one cycle after that CHECK cycle.
- `GVC_STOP_ON_ERR_EN` undefined: all four vectors are always checked, as described in Operation.

## Test plan
- Correct AND gate, default parameters, pulse `start` → `done` in cycle 13, `pass=1`, `err_count=0`, `a/b` sequence 00,01,10,11 with each vector held 3 cycles.
- `y` stuck at 0 → `err_count=1`, `first_err_vec=2'b11`, `pass=0`.
- `y` stuck at 1 → `err_count=3`, `first_err_vec=2'b00`, `pass=0`. With `GVC_STOP_ON_ERR_EN`: `err_count=1` and `done` in cycle 4.
- `y` driven by an OR gate → `err_count=2`, `first_err_vec=2'b01`, `pass=0`.
- `start` pulsed again in cycle 5 of a sweep → ignored, `done` still in cycle 13.
- `rst` asserted in cycle 7 → all outputs at reset values immediately. A new `start` after reset gives a clean 13-cycle sweep.
